spi_bus_scheduler: RTL and testbench
====================================

# spi_bus_scheduler

- Shares one SPI master bus (mode 0: CPOL=0, CPHA=0) between two requesters.
- Arbitrates round-robin, drives a per-requester chip select, generates SCLK from the system clock, and runs one full-duplex word transfer per grant.
- Sits between the control logic that owns each slave and the SPI pins; replaces ad-hoc CS/SCLK sequencing.

## Interface
- DATA_W, 8: bits per transfer, MSB first
- CLK_DIV, 2: clk cycles per SCLK half-period, ≥1
- clk  in  1  system clock; all logic on posedge
- b0  in  1  asynchronous active-low reset
- req  in  2  per-requester transfer request, level; held until ack
- tx_data0  in  DATA_W  word for requester 0, sampled at grant
- tx_data1  in  DATA_W  word for requester 1, sampled at grant
- ack  out  2  one-cycle pulse to the served requester at end of transfer
- rx_data  out  DATA_W  received word, valid while rx_valid, held afterwards
- rx_valid  out  1  one-cycle pulse, coincident with ack
- busy  out  1  high from grant through the GAP state
- cs_n  out  2  active-low chip select, one per requester
- sclk  out  1  SPI clock, idles low
- mosi  out  1  serial data out
- miso  in  1  serial data in

## Operation
- Reset values (immediate, asynchronous): cs_n=2'b11, sclk=0, mosi=0, ack=0, rx_valid=0, rx_data=0, busy=0, state=IDLE, last-grant pointer=1 (requester 0 wins first).
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - If any req is high, grant it.
  - If both are high, grant the one not granted last.
  - On grant: latch tx_dataN; drive cs_n[N]=0 and mosi=tx[DATA_W-1]; set busy; update pointer; go to SETUP.
- SETUP: sclk low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: DATA_W SCLK periods.
  - On each rising sclk edge, sample miso into the LSB of the rx shift register.
  - On each falling edge except the last, shift mosi to the next bit.
  - After the last falling edge, go to HOLD.
- HOLD: sclk low, cs still asserted, for CLK_DIV cycles. Then:
  - cs_n=11;
  - ack[N]=1 and rx_valid=1 for one cycle, with rx_data updated;
  - go to GAP.
- GAP: cs_n high for CLK_DIV cycles (minimum deselect time), then go to IDLE. busy drops on entering IDLE.
- req dropped before grant: request is withdrawn, no transfer. req dropped mid-transfer: ignored, the transfer completes and ack is still pulsed.
- mosi holds its last bit outside SHIFT, then returns to 0 in IDLE.
- Only one cs_n bit is ever low.

## Timing
- Grant at posedge t: cs_n[N] falls after edge t.
- cs_n stays low for CLK_DIV*(2*DATA_W+2) cycles (36 with defaults).
- First sclk rise at t+CLK_DIV; SCLK period is 2*CLK_DIV clk cycles.
- ack and rx_valid are high from edge t+36 to t+37 (defaults); cs_n rises at the same edge.
- Earliest next grant is edge t+36+CLK_DIV (t+38 with defaults). Back-to-back throughput is one word per 38 cycles.
- Bit counter width is clog2(DATA_W+1). Divider counter wraps at CLK_DIV-1.

## Structure
- Package spi_pkg holds the state enum (IDLE, SETUP, SHIFT, HOLD, GAP) and the default DATA_W/CLK_DIV constants.
- Sub-module spi_shift_reg:
  - parallel load, MSB-first shift out, LSB shift in, bit counter, last_bit flag;
  - driven by sclk_rise/sclk_fall strobes from the scheduler.
- Divider, arbiter and FSM remain in spi_bus_scheduler.

## Test plan
- req=01, tx_data0=0xA5, miso looped to mosi -> cs_n=10 for 36 cycles, 8 sclk rises, rx_data=0xA5, ack=01 for one cycle.
- req=11 released from reset on the same edge -> requester 0 served first, then requester 1 starts 2 cycles after ack[0]; cs_n never 00.
- Both req held for 4 transfers -> ack order 0,1,0,1; each transfer 36 cs-low cycles with 2-cycle gaps.
- b0 pulsed low during SHIFT after 4 sclk rises -> cs_n=11 and sclk=0 immediately. A new req0 afterwards sends the full word from bit 7.
- miso held at 1 -> rx 0xFF; miso held at 0 -> rx 0x00. Repeat with CLK_DIV=1: cs low for 18 cycles.
- req0 pulsed for 1 cycle while requester 1 is mid-transfer, dropped before IDLE -> no grant to requester 0, no ack[0].

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI bus scheduler slice.
//   state_t     - scheduler FSM states
//   DEF_DATA_W  - default bits per transfer
//   DEF_CLK_DIV - default clk cycles per SCLK half-period
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_CLK_DIV = 2;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: full-duplex SPI data path for one word, MSB first.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_load         - parallel load of i_load_data (clears rx and bit count)
//   i_clear        - clear the tx register so mosi rests at 0
//   i_rise/i_fall  - SCLK edge strobes from the scheduler
//   i_miso         - serial in, sampled into the LSB on i_rise
//   o_mosi         - current tx bit (tx register MSB)
//   o_rx           - received word
//   o_last_bit     - all DATA_W bits have been sampled
module spi_shift_reg import spi_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_rise,
  input  logic              i_fall,
  input  logic              i_miso,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx,
  output logic              o_last_bit
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_tx  <= i_load_data;
      r_rx  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_tx <= '0;
    end else begin
      if (i_rise) begin
        r_rx  <= {r_rx[DATA_W-2:0], i_miso};
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // the final falling edge leaves the last bit on mosi
      if (i_fall && !o_last_bit) begin
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign o_last_bit = (r_cnt == CNT_W'(DATA_W));
  assign o_mosi     = r_tx[DATA_W-1];
  assign o_rx       = r_rx;

endmodule

// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin sharing of one SPI mode-0 master bus
// between two requesters, one full-duplex word per grant.
//   clk, b0            - clock, asynchronous active-low reset
//   req[1:0]           - level requests, held until ack
//   tx_data0/tx_data1  - words to send, sampled at grant
//   ack[1:0]           - one-cycle pulse to the served requester
//   rx_data, rx_valid  - received word and its one-cycle valid
//   busy               - high from grant until the FSM returns to IDLE
//   cs_n[1:0]          - active-low chip selects
//   sclk, mosi, miso   - SPI pins
module spi_bus_scheduler import spi_pkg::*; #(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              b0,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] tx_data0,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic [1:0]        cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic              r_last;
  logic              r_sel;
  logic              r_sclk;
  logic              r_rx_valid;
  logic [1:0]        r_cs_n;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rx_data;

  logic              w_tick;
  logic              w_gsel;
  logic              w_grant;
  logic              w_rise;
  logic              w_fall;
  logic              w_done;
  logic              w_clear;
  logic              w_last_bit;
  logic              w_mosi;
  logic [DATA_W-1:0] w_rx;
  logic [DATA_W-1:0] w_load_data;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // round-robin: on contention the requester not served last wins
  always_comb begin
    w_gsel = 1'b0;
    case (req)
      2'b10:   w_gsel = 1'b1;
      2'b11:   w_gsel = ~r_last;
      default: w_gsel = 1'b0;
    endcase
  end

  assign w_load_data = w_gsel ? tx_data1 : tx_data0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_grant     = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_rise      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // after the last fall, sclk stays low one more half-period before HOLD
        if (w_tick) begin
          if (r_sclk)          w_fall      = 1'b1;
          else if (w_last_bit) w_state_nxt = HOLD;
          else                 w_rise      = 1'b1;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_done      = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        // a waiting request is granted on the edge that ends the deselect
        // time, giving back-to-back words every CLK_DIV*(2*DATA_W+3) cycles
        if (w_tick) begin
          if (|req) begin
            w_grant     = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge b0) begin
    if (!b0) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge b0) begin
    if (!b0) begin
      r_div      <= '0;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= '1;
      r_ack      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_ack      <= '0;
      r_rx_valid <= 1'b0;
      r_div      <= (r_state == IDLE || w_tick) ? '0 : r_div + DIV_W'(1);
      if (w_grant) begin
        r_sel  <= w_gsel;
        r_last <= w_gsel;
        r_cs_n <= w_gsel ? 2'b01 : 2'b10;
      end
      if (w_rise) r_sclk <= 1'b1;
      if (w_fall) r_sclk <= 1'b0;
      if (w_done) begin
        r_cs_n     <= '1;
        r_ack      <= r_sel ? 2'b10 : 2'b01;
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_rx;
      end
    end
  end

  spi_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .i_clk       (clk),
    .i_rst_n     (b0),
    .i_load      (w_grant),
    .i_clear     (w_clear),
    .i_load_data (w_load_data),
    .i_rise      (w_rise),
    .i_fall      (w_fall),
    .i_miso      (miso),
    .o_mosi      (w_mosi),
    .o_rx        (w_rx),
    .o_last_bit  (w_last_bit)
  );

  assign ack      = r_ack;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != IDLE);
  assign cs_n     = r_cs_n;
  assign sclk     = r_sclk;
  assign mosi     = w_mosi;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: scoreboard bench for spi_bus_scheduler.
// Main instance uses defaults (DATA_W=8, CLK_DIV=2); a second instance
// runs with CLK_DIV=1.
module tb_spi_bus_scheduler;

  localparam int unsigned CD     = 2;
  localparam int unsigned CS_LOW = CD * (2 * 8 + 2);

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       b0;
  logic [1:0] req;
  logic [7:0] tx_data0, tx_data1;
  logic [1:0] ack;
  logic [7:0] rx_data;
  logic       rx_valid, busy, sclk, mosi, miso;
  logic [1:0] cs_n;
  logic [1:0] mode;

  logic [1:0] f_req;
  logic [7:0] f_tx0, f_tx1;
  logic [1:0] f_ack;
  logic [7:0] f_rx_data;
  logic       f_rxv, f_busy, f_sclk, f_mosi, f_miso;
  logic [1:0] f_cs_n;
  logic [1:0] f_mode;

  // mode 0: miso looped to mosi, 1: held high, 2: held low
  assign miso   = (mode == 2'd0)   ? mosi   : (mode == 2'd1);
  assign f_miso = (f_mode == 2'd0) ? f_mosi : (f_mode == 2'd1);

  spi_bus_scheduler #(.DATA_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .b0(b0), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .ack(ack), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_bus_scheduler #(.DATA_W(8), .CLK_DIV(1)) dut_fast (
    .clk(clk), .b0(b0), .req(f_req), .tx_data0(f_tx0), .tx_data1(f_tx1),
    .ack(f_ack), .rx_data(f_rx_data), .rx_valid(f_rxv), .busy(f_busy),
    .cs_n(f_cs_n), .sclk(f_sclk), .mosi(f_mosi), .miso(f_miso)
  );

  typedef struct {
    int         id;
    logic [7:0] rx;
    int         gap;   // expected cs_n-high cycles before this transfer, 0 = unchecked
  } exp_t;

  exp_t       sb[$];
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];

  int n_tests  = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_ack    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int id, input logic [7:0] d, input int gap);
    exp_t e;
    e.id  = id;
    e.rx  = (mode == 2'd0) ? d : (mode == 2'd1) ? 8'hFF : 8'h00;
    e.gap = gap;
    sb.push_back(e);
    n_pushed++;
    if (id == 0) begin
      txq0.push_back(d);
      if (!req[0]) begin tx_data0 = d; req[0] = 1'b1; end
    end else begin
      txq1.push_back(d);
      if (!req[1]) begin tx_data1 = d; req[1] = 1'b1; end
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("drain", sb.size(), 0);
  endtask

  // requester model: drop req on ack unless more words are queued
  initial begin
    logic [7:0] tmp;
    forever begin
      @(negedge clk); #1;
      if (ack[0] && txq0.size() > 0) begin
        tmp = txq0.pop_front();
        if (txq0.size() > 0) tx_data0 = txq0[0]; else req[0] = 1'b0;
      end
      if (ack[1] && txq1.size() > 0) begin
        tmp = txq1.pop_front();
        if (txq1.size() > 0) tx_data1 = txq1[0]; else req[1] = 1'b0;
      end
    end
  end

  // bus monitor for the main instance
  int         cs_cnt, rises, gap_cnt;
  logic       prev_sclk, prev_rxv, saw00;
  logic [1:0] prev_cs;
  initial saw00 = 1'b0;

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] sel;
    if (!b0) begin
      cs_cnt = 0; rises = 0; gap_cnt = 0;
      prev_sclk = 1'b0; prev_rxv = 1'b0; prev_cs = 2'b11;
    end else begin
      if (cs_n == 2'b00) saw00 = 1'b1;
      if (sclk && !prev_sclk) rises++;
      if (prev_rxv) check("ack_one_cycle", {ack, rx_valid}, 3'b000);
      if (cs_n != 2'b11) begin
        if (prev_cs == 2'b11) begin
          if (sb.size() > 0) begin
            sel = (sb[0].id == 0) ? 2'b10 : 2'b01;
            check("cs_sel", cs_n, sel);
            if (sb[0].gap != 0) check("gap", gap_cnt, sb[0].gap);
          end else begin
            check("cs_unexpected", cs_n, 2'b11);
          end
        end
        cs_cnt++;
      end else begin
        gap_cnt++;
      end
      if (rx_valid) begin
        n_ack++;
        if (sb.size() == 0) begin
          check("ack_unexpected", ack, 2'b00);
        end else begin
          e   = sb.pop_front();
          sel = (e.id == 0) ? 2'b01 : 2'b10;
          check("ack", ack, sel);
          check("rx_data", rx_data, e.rx);
          check("cs_low_cycles", cs_cnt, CS_LOW);
          check("sclk_rises", rises, 8);
        end
        cs_cnt = 0; rises = 0; gap_cnt = 1;
      end
      prev_sclk = sclk;
      prev_cs   = cs_n;
      prev_rxv  = rx_valid;
    end
  end

  task automatic fast_xfer(input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp_rx);
    int   low = 0, fr = 0, k = 0;
    logic ps  = 1'b0;
    f_mode = m; f_tx0 = d; f_req = 2'b01;
    while (!f_rxv && k < 100) begin
      @(negedge clk); #1;
      if (f_cs_n != 2'b11) low++;
      if (f_sclk && !ps) fr++;
      ps = f_sclk;
      k++;
    end
    f_req = 2'b00;
    check("fast_cs_low", low, 18);
    check("fast_rises", fr, 8);
    check("fast_rx", f_rx_data, exp_rx);
    check("fast_ack", f_ack, 2'b01);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    b0 = 1'b0; req = 2'b00; tx_data0 = '0; tx_data1 = '0; mode = 2'd0;
    f_req = 2'b00; f_tx0 = '0; f_tx1 = '0; f_mode = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", cs_n, 2'b11);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ack", {ack, rx_valid}, 3'b000);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);

    // both requests present as reset releases: requester 0 first, then 1 after 2 cycles
    issue(0, 8'h5A, 0);
    issue(1, 8'hC3, CD);
    b0 = 1'b1;
    wait_done(400);

    // both held for four words: 0,1,0,1 back to back
    issue(0, 8'h01, 0);
    issue(1, 8'h80, CD);
    issue(0, 8'h7E, CD);
    issue(1, 8'hE7, CD);
    wait_done(800);

    // single request, loopback
    issue(0, 8'hA5, 0);
    wait_done(200);

    // constant miso levels
    mode = 2'd1; issue(0, 8'h00, 0); wait_done(200);
    mode = 2'd2; issue(1, 8'hFF, 0); wait_done(200);
    mode = 2'd0;

    // req0 pulsed while requester 1 is mid-transfer: withdrawn, never served
    issue(1, 8'h96, 0);
    repeat (12) @(negedge clk);
    #1;
    check("drop_busy", busy, 1'b1);
    tx_data0 = 8'hFF; req[0] = 1'b1;
    @(negedge clk); #1;
    req[0] = 1'b0;
    wait_done(200);
    repeat (10) @(negedge clk);
    #1;
    check("drop_idle_cs", cs_n, 2'b11);
    check("drop_idle_busy", busy, 1'b0);

    // reset during SHIFT after 4 sclk rises
    issue(0, 8'hB4, 0);
    k = 0;
    while (rises < 4 && k < 200) begin @(negedge clk); #1; k++; end
    check("rises_before_rst", rises, 4);
    b0 = 1'b0;
    #1;
    check("rst_mid_cs_n", cs_n, 2'b11);
    check("rst_mid_sclk", sclk, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    n_pushed -= sb.size();
    sb.delete(); txq0.delete(); req = 2'b00;
    @(negedge clk); #1;
    b0 = 1'b1;
    issue(0, 8'h3C, 0);
    wait_done(200);

    // CLK_DIV=1 instance
    fast_xfer(8'h69, 2'd0, 8'h69);
    fast_xfer(8'h00, 2'd1, 8'hFF);
    fast_xfer(8'hFF, 2'd2, 8'h00);

    check("ack_count", n_ack, n_pushed);
    check("cs_never_00", saw00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
